bbox_tracker: RTL and testbench
===============================

// Module: bbox_tracker
// PURPOSE
// - Streaming bounding-box extractor for one image frame, for ingredient localisation.
// - Accepts CHANNELS bytes per pixel in raster order over a valid/ready stream.
// - Reports the min/max x/y of all foreground (non-background) pixels.
// - Sits between the HPS pixel-write path and the crop/classify stage; frame-based with start/done.
// PARAMETERS
// - WIDTH      default 100  pixels per row, >=2
// - HEIGHT     default 100  rows per frame, >=2
// - CHANNELS   default 3    bytes per pixel (1..4)
// - THRESHOLD  default 245  a byte < THRESHOLD is "dark"; pixel is foreground if ANY channel is dark
// - XW = $clog2(WIDTH), YW = $clog2(HEIGHT)  derived localparams, not overridable
// PORTS
// - CLOCK_50  in   1   system clock, all logic on rising edge
// - reset_n   in   1   synchronous reset, active-low
// - start     in   1   1-cycle pulse: clear results, begin new frame
// - s_valid   in   1   sample valid
// - s_data    in   8   sample byte (channel order 0..CHANNELS-1 within a pixel)
// - s_ready   out  1   block accepts sample; transfer = s_valid & s_ready
// - busy      out  1   high in SCAN
// - done      out  1   high in DONE; results stable and final
// - empty     out  1   no foreground pixel in frame so far
// - x_min     out  XW  min foreground x;  x_max out XW;  y_min out YW;  y_max out YW
// - fg_count  out  XW+YW+1  foreground pixel count (only with BBOX_FG_COUNT_EN)
// BEHAVIOUR
// - Reset: state=IDLE; s_ready=0, busy=0, done=0, empty=1.
//   x_min=WIDTH-1, x_max=0, y_min=HEIGHT-1, y_max=0; counters ch=0, x=0, y=HEIGHT-1; fg_count=0.
// - FSM IDLE -> (start) SCAN -> (last sample accepted) DONE -> (start) SCAN. No other transitions.
// - s_ready = (state==SCAN), combinational from state only. s_valid gaps are allowed; counters hold.
// - Scan order: bottom-up rows (BMP order). y starts at HEIGHT-1, x at 0, ch at 0.
//   Per transfer: ch++; at ch==CHANNELS-1 -> ch=0, x++; at x==WIDTH-1 -> x=0, y--.
// - Dark flag: OR of (s_data<THRESHOLD) over the pixel's channels. Accumulator is cleared at ch==0.
// - Foreground decision is made on the transfer with ch==CHANNELS-1, at the current x,y.
//   Box registers update on that same edge: x_min=min(x_min,x), x_max=max(...), etc.
//   empty clears on that same edge.
//   First foreground pixel loads all four box registers directly: x_min=x_max=x, y_min=y_max=y.
// - Last sample = transfer with ch==CHANNELS-1, x==WIDTH-1, y==0.
//   The next cycle is DONE, with done=1 and final box already visible (1-cycle latency).
// - In DONE, further s_valid is ignored (s_ready=0). done holds until start.
// - start in any state, including mid-SCAN: next cycle = SCAN.
//   Box, empty, counters and fg_count are re-initialised to reset values; a sample presented
//   in the start cycle is NOT accepted (s_ready follows the old state but is masked by start).
// - reset_n low mid-frame: reset values next edge; reset has priority over start.
// - When empty=1, box outputs hold reset values; consumers must qualify with empty.
// CONFIGURATION
// - BBOX_FG_COUNT_EN defined: fg_count port exists, increments by 1 per foreground pixel, saturates
//   at all-ones, cleared by reset/start.
// - BBOX_FG_COUNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING  (WIDTH=4, HEIGHT=4, CHANNELS=3, THRESHOLD=245 unless noted)
// - All 48 bytes = 255 -> done 1 cycle after last transfer, empty=1, box=(3,0,3,0), fg_count=0.
// - Pixel #5 of stream = {250,200,255}, rest 255 -> x_min=x_max=1, y_min=y_max=2, empty=0,
//   fg_count=1.
// - Pixels #0 and #15 dark (0,0,0) -> box x 0..3, y 0..3, fg_count=2; s_valid toggled 1/0 each
//   cycle gives same result.
// - start asserted after 20 bytes of frame A, then full frame B with only pixel #10 dark ->
//   box x=2,y=1 only; no residue from A.
// - reset_n low for 1 cycle mid-frame -> IDLE, s_ready=0, all outputs at reset values;
//   s_valid ignored until start.
// - In DONE, drive 10 extra s_valid bytes of 0 -> s_ready=0, box/done unchanged.

Source files
------------

// File: rtl/bbox_tracker.sv
`default_nettype none
// ============================================================================
// Module  : bbox_tracker
// Brief   : Streaming foreground bounding-box extractor for one raster frame.
//           Optional foreground pixel counter enabled by BBOX_FG_COUNT_EN.
// Revision: 1.0
// ============================================================================
module bbox_tracker #(
    parameter int WIDTH     = 100,
    parameter int HEIGHT    = 100,
    parameter int CHANNELS  = 3,
    parameter int THRESHOLD = 245,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT)
) (
    input  logic          CLOCK_50,
    input  logic          reset_n,
    input  logic          start,
    input  logic          s_valid,
    input  logic [7:0]    s_data,
    output logic          s_ready,
    output logic          busy,
    output logic          done,
    output logic          empty,
    output logic [XW-1:0] x_min,
    output logic [XW-1:0] x_max,
    output logic [YW-1:0] y_min,
    output logic [YW-1:0] y_max
`ifdef BBOX_FG_COUNT_EN
    ,
    output logic [XW+YW:0] fg_count
`endif
);

    localparam int              CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [1:0]      S_IDLE    = 2'd0;
    localparam logic [1:0]      S_SCAN    = 2'd1;
    localparam logic [1:0]      S_DONE    = 2'd2;
    localparam logic [CW-1:0]   C_CH_LAST = CW'(CHANNELS - 1);
    localparam logic [XW-1:0]   C_X_LAST  = XW'(WIDTH - 1);
    localparam logic [YW-1:0]   C_Y_LAST  = YW'(HEIGHT - 1);
    localparam logic [7:0]      C_THR     = 8'(THRESHOLD);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] ch_q, ch_d;
    logic [XW-1:0] x_q, x_d, x_min_q, x_min_d, x_max_q, x_max_d;
    logic [YW-1:0] y_q, y_d, y_min_q, y_min_d, y_max_q, y_max_d;
    logic          dark_q, dark_d, empty_q, empty_d;
`ifdef BBOX_FG_COUNT_EN
    logic [XW+YW:0] fg_count_q, fg_count_d;
`endif

    logic w_xfer, w_pix_dark, w_pix_end, w_last;

    // A sample presented alongside start is dropped: start re-arms the frame instead.
    assign w_xfer     = s_valid & s_ready & ~start;
    assign w_pix_dark = ((ch_q == '0) ? 1'b0 : dark_q) | (s_data < C_THR);
    assign w_pix_end  = (ch_q == C_CH_LAST);
    assign w_last     = w_xfer & w_pix_end & (x_q == C_X_LAST) & (y_q == '0);

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            x_q     <= '0;
            y_q     <= C_Y_LAST;
            dark_q  <= 1'b0;
            empty_q <= 1'b1;
            x_min_q <= C_X_LAST;
            x_max_q <= '0;
            y_min_q <= C_Y_LAST;
            y_max_q <= '0;
`ifdef BBOX_FG_COUNT_EN
            fg_count_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dark_q  <= dark_d;
            empty_q <= empty_d;
            x_min_q <= x_min_d;
            x_max_q <= x_max_d;
            y_min_q <= y_min_d;
            y_max_q <= y_max_d;
`ifdef BBOX_FG_COUNT_EN
            fg_count_q <= fg_count_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = S_SCAN;
        end else if (state_q == S_SCAN && w_last) begin
            state_d = S_DONE;
        end
    end

    always_comb begin
        ch_d    = ch_q;
        x_d     = x_q;
        y_d     = y_q;
        dark_d  = dark_q;
        empty_d = empty_q;
        x_min_d = x_min_q;
        x_max_d = x_max_q;
        y_min_d = y_min_q;
        y_max_d = y_max_q;
`ifdef BBOX_FG_COUNT_EN
        fg_count_d = fg_count_q;
`endif
        if (start) begin
            ch_d    = '0;
            x_d     = '0;
            y_d     = C_Y_LAST;
            dark_d  = 1'b0;
            empty_d = 1'b1;
            x_min_d = C_X_LAST;
            x_max_d = '0;
            y_min_d = C_Y_LAST;
            y_max_d = '0;
`ifdef BBOX_FG_COUNT_EN
            fg_count_d = '0;
`endif
        end else if (w_xfer) begin
            dark_d = w_pix_dark;
            if (w_pix_end) begin
                ch_d = '0;
                if (x_q == C_X_LAST) begin
                    x_d = '0;
                    y_d = y_q - 1'b1;
                end else begin
                    x_d = x_q + 1'b1;
                end
                if (w_pix_dark) begin
                    empty_d = 1'b0;
                    // First foreground pixel seeds the box; later ones widen it.
                    x_min_d = (empty_q || x_q < x_min_q) ? x_q : x_min_q;
                    x_max_d = (empty_q || x_q > x_max_q) ? x_q : x_max_q;
                    y_min_d = (empty_q || y_q < y_min_q) ? y_q : y_min_q;
                    y_max_d = (empty_q || y_q > y_max_q) ? y_q : y_max_q;
`ifdef BBOX_FG_COUNT_EN
                    if (fg_count_q != '1) begin
                        fg_count_d = fg_count_q + 1'b1;
                    end
`endif
                end
            end else begin
                ch_d = ch_q + 1'b1;
            end
        end
    end

    always_comb begin
        s_ready = (state_q == S_SCAN);
        busy    = (state_q == S_SCAN);
        done    = (state_q == S_DONE);
    end

    assign empty = empty_q;
    assign x_min = x_min_q;
    assign x_max = x_max_q;
    assign y_min = y_min_q;
    assign y_max = y_max_q;
`ifdef BBOX_FG_COUNT_EN
    assign fg_count = fg_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bbox_tracker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_bbox_tracker
// Brief   : Directed self-checking bench for bbox_tracker (4x4, 3 channels).
// Revision: 1.0
// ============================================================================
module tb_bbox_tracker;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int CH = 3;
    localparam int TH = 245;
    localparam int NB = W * H * CH;

    logic       CLOCK_50 = 1'b0;
    logic       reset_n  = 1'b0;
    logic       start    = 1'b0;
    logic       s_valid  = 1'b0;
    logic [7:0] s_data   = 8'd0;
    logic       s_ready, busy, done, empty;
    logic [1:0] x_min, x_max, y_min, y_max;
`ifdef BBOX_FG_COUNT_EN
    logic [4:0] fg_count;
`endif

    bbox_tracker #(
        .WIDTH(W), .HEIGHT(H), .CHANNELS(CH), .THRESHOLD(TH)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset_n (reset_n),
        .start   (start),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .busy    (busy),
        .done    (done),
        .empty   (empty),
        .x_min   (x_min),
        .x_max   (x_max),
        .y_min   (y_min),
        .y_max   (y_max)
`ifdef BBOX_FG_COUNT_EN
        ,
        .fg_count(fg_count)
`endif
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [31:0] empty;
        logic [31:0] xmin, xmax, ymin, ymax;
        logic [31:0] fg;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] frame [NB];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < NB; i++) frame[i] = v;
    endtask

    task automatic set_pix(input int p, input logic [7:0] c0, c1, c2);
        frame[p*CH]   = c0;
        frame[p*CH+1] = c1;
        frame[p*CH+2] = c2;
    endtask

    // Whole-frame reference: pixel p sits at x=p%W, y=H-1-p/W (bottom-up rows).
    task automatic model_push();
        exp_t e;
        int   n = 0;
        e.xmin = W - 1; e.xmax = 0; e.ymin = H - 1; e.ymax = 0;
        for (int p = 0; p < W * H; p++) begin
            bit dk = 0;
            for (int c = 0; c < CH; c++) if (int'(frame[p*CH+c]) < TH) dk = 1;
            if (dk) begin
                int px = p % W;
                int py = H - 1 - p / W;
                if (n == 0 || px < int'(e.xmin)) e.xmin = px;
                if (n == 0 || px > int'(e.xmax)) e.xmax = px;
                if (n == 0 || py < int'(e.ymin)) e.ymin = py;
                if (n == 0 || py > int'(e.ymax)) e.ymax = py;
                n++;
            end
        end
        e.empty = (n == 0) ? 1 : 0;
        e.fg    = n;
        sb.push_back(e);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 0);
        chk({tag, "_busy"},    32'(busy),    0);
        chk({tag, "_done"},    32'(done),    0);
        chk({tag, "_empty"},   32'(empty),   1);
        chk({tag, "_box"},     {24'd0, x_min, x_max, y_min, y_max}, {24'd0, 2'd3, 2'd0, 2'd3, 2'd0});
`ifdef BBOX_FG_COUNT_EN
        chk({tag, "_fg"},      32'(fg_count), 0);
`endif
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 32'(busy), 1);
        chk("start_empty", 32'(empty), 1);
    endtask

    task automatic send_bytes(input int n, input bit toggle);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = frame[i];
            tick();
            if (toggle && i < n - 1) begin
                s_valid = 1'b0;
                s_data  = 8'd0;
                tick();
            end
        end
        s_valid = 1'b0;
        s_data  = 8'd0;
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_empty"}, 32'(empty), e.empty);
            chk({tag, "_x_min"}, 32'(x_min), e.xmin);
            chk({tag, "_x_max"}, 32'(x_max), e.xmax);
            chk({tag, "_y_min"}, 32'(y_min), e.ymin);
            chk({tag, "_y_max"}, 32'(y_max), e.ymax);
`ifdef BBOX_FG_COUNT_EN
            chk({tag, "_fg"},    32'(fg_count), e.fg);
`endif
        end
    endtask

    task automatic run_frame(input string tag, input bit toggle);
        pulse_start();
        model_push();
        send_bytes(NB, toggle);
        check_result(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) tick();
        check_idle("reset");
        reset_n = 1'b1;
        tick();
        check_idle("idle_after_reset");

        fill(8'd255);
        run_frame("all_bg", 1'b0);

        // Traffic while DONE must be refused and leave results alone.
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1;
            s_data  = 8'd0;
            chk("done_s_ready", 32'(s_ready), 0);
            tick();
        end
        s_valid = 1'b0;
        chk("done_hold", 32'(done), 1);
        chk("done_hold_empty", 32'(empty), 1);
        chk("done_hold_box", {24'd0, x_min, x_max, y_min, y_max}, {24'd0, 2'd3, 2'd0, 2'd3, 2'd0});

        fill(8'd255);
        set_pix(5, 8'd250, 8'd200, 8'd255);
        run_frame("pix5", 1'b0);

        fill(8'd255);
        set_pix(0, 8'd0, 8'd0, 8'd0);
        set_pix(15, 8'd0, 8'd0, 8'd0);
        run_frame("corners", 1'b0);
        run_frame("corners_gappy", 1'b1);

        // Abort frame A mid-stream, with a dark sample offered during start.
        fill(8'd0);
        pulse_start();
        send_bytes(20, 1'b0);
        chk("frameA_dirty", 32'(empty), 0);
        s_valid = 1'b1;
        s_data  = 8'd0;
        pulse_start();
        s_valid = 1'b0;
        fill(8'd255);
        set_pix(10, 8'd0, 8'd0, 8'd0);
        model_push();
        send_bytes(NB, 1'b0);
        check_result("restart_B");

        // Reset in the middle of a frame.
        fill(8'd0);
        pulse_start();
        send_bytes(20, 1'b0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_idle("mid_reset");
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = 8'd0;
            tick();
        end
        s_valid = 1'b0;
        check_idle("idle_ignores_valid");

        fill(8'd255);
        set_pix(5, 8'd250, 8'd200, 8'd255);
        run_frame("after_reset", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
